// File: rtl/mma_sched_pkg.sv
// rtl/mma_sched_pkg.sv - shared state, command type and defaults for the tile scheduler
package mma_sched_pkg;

  localparam int DEF_IDXW = 8;
  localparam int DEF_ILV  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_IDXW-1:0] m;
    logic [DEF_IDXW-1:0] n;
    logic [DEF_IDXW-1:0] k;
    logic                first;
    logic                last;
  } tile_cmd_t;

endpackage

// File: rtl/mma_tile_iter.sv
// rtl/mma_tile_iter.sv - nested (group, k, j) tile index counter with registered command fields
module mma_tile_iter #(
  parameter int IDXW = 8,
  parameter int ILV  = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            init_i,
  input  logic            next_i,
  input  logic [IDXW-1:0] m_tiles_i,
  input  logic [IDXW-1:0] n_tiles_i,
  input  logic [IDXW-1:0] k_tiles_i,
  output logic [IDXW-1:0] m_o,
  output logic [IDXW-1:0] n_o,
  output logic [IDXW-1:0] k_o,
  output logic            first_o,
  output logic            last_o,
  output logic            wrap_o,
  output logic [$clog2(ILV+1)-1:0] grp_d_o
);

  localparam int GW = $clog2(ILV+1);
  localparam int TW = 2 * IDXW;

  // Group size for the tiles still left: min(ILV, remaining).
  function automatic logic [GW-1:0] grp_of(input logic [TW-1:0] rem);
    if (rem >= TW'(ILV)) grp_of = GW'(ILV);
    else                 grp_of = rem[GW-1:0];
  endfunction

  logic [IDXW-1:0] n_tiles_q, n_tiles_d, k_tiles_q, k_tiles_d;
  logic [TW-1:0]   total_q, total_d, tbase_q, tbase_d;
  logic [IDXW-1:0] bm_q, bm_d, bn_q, bn_d;
  logic [IDXW-1:0] cm_q, cm_d, cn_q, cn_d;
  logic [IDXW-1:0] k_q, k_d;
  logic [GW-1:0]   j_q, j_d, grp_q, grp_d;
  logic            first_q, first_d, last_q, last_d;
  logic [IDXW-1:0] step_n, nxt_m, nxt_n;
  logic            j_end, k_end;
  logic [TW-1:0]   rem_after;

  // Walk j across the group's tiles, then k, then advance to the next group of tiles.
  always_comb begin
    n_tiles_d = n_tiles_q;
    k_tiles_d = k_tiles_q;
    total_d   = total_q;
    tbase_d   = tbase_q;
    bm_d      = bm_q;
    bn_d      = bn_q;
    cm_d      = cm_q;
    cn_d      = cn_q;
    k_d       = k_q;
    j_d       = j_q;
    grp_d     = grp_q;

    step_n    = cn_q + 1'b1;
    nxt_m     = (step_n == n_tiles_q) ? cm_q + 1'b1 : cm_q;
    nxt_n     = (step_n == n_tiles_q) ? '0 : step_n;
    j_end     = (j_q == grp_q - 1'b1);
    k_end     = (k_q == k_tiles_q - 1'b1);
    rem_after = total_q - tbase_q - TW'(grp_q);

    if (init_i) begin
      n_tiles_d = n_tiles_i;
      k_tiles_d = k_tiles_i;
      total_d   = TW'(m_tiles_i) * TW'(n_tiles_i);
      tbase_d   = '0;
      bm_d      = '0;
      bn_d      = '0;
      cm_d      = '0;
      cn_d      = '0;
      k_d       = '0;
      j_d       = '0;
      grp_d     = grp_of(total_d);
    end else if (next_i) begin
      if (!j_end) begin
        j_d  = j_q + 1'b1;
        cm_d = nxt_m;
        cn_d = nxt_n;
      end else if (!k_end) begin
        j_d  = '0;
        k_d  = k_q + 1'b1;
        cm_d = bm_q;
        cn_d = bn_q;
      end else begin
        j_d     = '0;
        k_d     = '0;
        bm_d    = nxt_m;
        bn_d    = nxt_n;
        cm_d    = nxt_m;
        cn_d    = nxt_n;
        tbase_d = tbase_q + TW'(grp_q);
        grp_d   = grp_of(rem_after);
      end
    end

    first_d = (k_d == '0);
    last_d  = (k_d == k_tiles_d - 1'b1);
  end

  // Index state; everything clears so command fields read zero out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_tiles_q <= '0;
      k_tiles_q <= '0;
      total_q   <= '0;
      tbase_q   <= '0;
      bm_q      <= '0;
      bn_q      <= '0;
      cm_q      <= '0;
      cn_q      <= '0;
      k_q       <= '0;
      j_q       <= '0;
      grp_q     <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      n_tiles_q <= n_tiles_d;
      k_tiles_q <= k_tiles_d;
      total_q   <= total_d;
      tbase_q   <= tbase_d;
      bm_q      <= bm_d;
      bn_q      <= bn_d;
      cm_q      <= cm_d;
      cn_q      <= cn_d;
      k_q       <= k_d;
      j_q       <= j_d;
      grp_q     <= grp_d;
      first_q   <= first_d;
      last_q    <= last_d;
    end
  end

  assign m_o     = cm_q;
  assign n_o     = cn_q;
  assign k_o     = k_q;
  assign first_o = first_q;
  assign last_o  = last_q;
  assign wrap_o  = j_end && k_end && (tbase_q + TW'(grp_q) == total_q);
  assign grp_d_o = grp_d;

endmodule

// File: rtl/mma_tile_scheduler.sv
// rtl/mma_tile_scheduler.sv - tiled GEMM command scheduler; MMA_SCHED_PERF_EN adds perf counters
module mma_tile_scheduler
  import mma_sched_pkg::*;
#(
  parameter int IDXW = DEF_IDXW,
  parameter int ILV  = DEF_ILV
`ifdef MMA_SCHED_PERF_EN
  ,
  parameter int PERFW = 32
`endif
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [IDXW-1:0] m_tiles_i,
  input  logic [IDXW-1:0] n_tiles_i,
  input  logic [IDXW-1:0] k_tiles_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            cmd_valid_o,
  input  logic            cmd_ready_i,
  output logic [IDXW-1:0] cmd_m_o,
  output logic [IDXW-1:0] cmd_n_o,
  output logic [IDXW-1:0] cmd_k_o,
  output logic            cmd_first_o,
  output logic            cmd_last_o,
  input  logic            rsp_fire_i
`ifdef MMA_SCHED_PERF_EN
  ,
  output logic [PERFW-1:0] perf_busy_o,
  output logic [PERFW-1:0] perf_stall_o,
  output logic [PERFW-1:0] perf_cmds_o
`endif
);

  localparam int OUTW = $clog2(ILV+1);

  state_e          state_q, state_d;
  logic [OUTW-1:0] out_q, out_d;
  logic            valid_q, valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic            fire, accept, zero_cfg, rsp_bad, rsp_ok, iter_wrap;
  logic [OUTW-1:0] grp_d;

  assign fire     = valid_q & cmd_ready_i;
  assign accept   = (state_q == ST_IDLE) & start_i;
  assign zero_cfg = (m_tiles_i == '0) | (n_tiles_i == '0) | (k_tiles_i == '0);
  assign rsp_bad  = rsp_fire_i & (out_q == '0);
  assign rsp_ok   = rsp_fire_i & ~rsp_bad;

  mma_tile_iter #(
    .IDXW (IDXW),
    .ILV  (ILV)
  ) u_iter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .init_i    (accept),
    .next_i    (fire),
    .m_tiles_i (m_tiles_i),
    .n_tiles_i (n_tiles_i),
    .k_tiles_i (k_tiles_i),
    .m_o       (cmd_m_o),
    .n_o       (cmd_n_o),
    .k_o       (cmd_k_o),
    .first_o   (cmd_first_o),
    .last_o    (cmd_last_o),
    .wrap_o    (iter_wrap),
    .grp_d_o   (grp_d)
  );

  // Job sequencing, outstanding tracking and next-cycle values of every registered output.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    out_d   = out_q + OUTW'(fire) - OUTW'(rsp_ok);
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          err_d   = 1'b0;
          state_d = ST_ISSUE;
          if (zero_cfg) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_ISSUE: if (fire && iter_wrap) state_d = ST_DRAIN;
      ST_DRAIN: if (out_q == '0) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (rsp_bad) err_d = 1'b1;
    // Holding valid to outstanding < g keeps (tile, k) behind the retire of (tile, k-1).
    valid_d = (state_d == ST_ISSUE) && (out_d < grp_d);
    busy_d  = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d  = (state_d == ST_DONE);
  end

  // Control state and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

`ifdef MMA_SCHED_PERF_EN
  logic [PERFW-1:0] pbusy_q, pbusy_d, pstall_q, pstall_d, pcmds_q, pcmds_d;

  // Saturating job counters; in ISSUE a low valid means outstanding >= g.
  always_comb begin
    pbusy_d  = pbusy_q;
    pstall_d = pstall_q;
    pcmds_d  = pcmds_q;
    if (accept) begin
      pbusy_d  = '0;
      pstall_d = '0;
      pcmds_d  = '0;
    end else begin
      if (busy_q && !(&pbusy_q)) pbusy_d = pbusy_q + 1'b1;
      if ((state_q == ST_ISSUE) && !valid_q && !(&pstall_q)) pstall_d = pstall_q + 1'b1;
      if (fire && !(&pcmds_q)) pcmds_d = pcmds_q + 1'b1;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pbusy_q  <= '0;
      pstall_q <= '0;
      pcmds_q  <= '0;
    end else begin
      pbusy_q  <= pbusy_d;
      pstall_q <= pstall_d;
      pcmds_q  <= pcmds_d;
    end
  end

  assign perf_busy_o  = pbusy_q;
  assign perf_stall_o = pstall_q;
  assign perf_cmds_o  = pcmds_q;
`endif

endmodule

// File: tb/tb_mma_tile_scheduler.sv
// tb/tb_mma_tile_scheduler.sv - randomized self-checking bench for mma_tile_scheduler
`timescale 1ns/1ps
module tb_mma_tile_scheduler;
  import mma_sched_pkg::*;

  localparam int IDXW = 8;
  localparam int ILV  = 4;

  logic            clk = 1'b0;
  logic            rst_i, start_i, cmd_ready_i, rsp_fire_i;
  logic [IDXW-1:0] m_tiles_i, n_tiles_i, k_tiles_i;
  logic            busy_o, done_o, err_o, cmd_valid_o, cmd_first_o, cmd_last_o;
  logic [IDXW-1:0] cmd_m_o, cmd_n_o, cmd_k_o;
`ifdef MMA_SCHED_PERF_EN
  logic [31:0]     perf_busy_o, perf_stall_o, perf_cmds_o;
`endif

  always #5 clk = ~clk;

  mma_tile_scheduler #(.IDXW(IDXW), .ILV(ILV)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .m_tiles_i   (m_tiles_i),
    .n_tiles_i   (n_tiles_i),
    .k_tiles_i   (k_tiles_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready_i),
    .cmd_m_o     (cmd_m_o),
    .cmd_n_o     (cmd_n_o),
    .cmd_k_o     (cmd_k_o),
    .cmd_first_o (cmd_first_o),
    .cmd_last_o  (cmd_last_o),
    .rsp_fire_i  (rsp_fire_i)
`ifdef MMA_SCHED_PERF_EN
    ,
    .perf_busy_o  (perf_busy_o),
    .perf_stall_o (perf_stall_o),
    .perf_cmds_o  (perf_cmds_o)
`endif
  );

  int errors = 0;
  int checks = 0;
  int n_fire, n_last, n_done, first_fire, last_fire, last_ret, done_cyc, max_out, busy_bad;
  bit timed_out;

  // Runs one job against an in-order MAC model; expected command list comes from the
  // group/k/j loop nest with tile t = m*n_tiles + n.
  task automatic run_job(input int mt, input int nt, input int kt,
                         input int ready_pct, input int lat_min, input int lat_max);
    tile_cmd_t exp_q[$];
    int        exp_g[$];
    int        ret_q[$];
    tile_cmd_t cur, held;
    bit        stalled, fire, got_done;
    int        cyc, model_out, lat, tot, g;
    tot = mt * nt;
    for (int tb = 0; tb < tot; tb += ILV) begin
      g = (tot - tb < ILV) ? tot - tb : ILV;
      for (int kk = 0; kk < kt; kk++) begin
        for (int jj = 0; jj < g; jj++) begin
          cur.m     = IDXW'((tb + jj) / nt);
          cur.n     = IDXW'((tb + jj) % nt);
          cur.k     = IDXW'(kk);
          cur.first = (kk == 0);
          cur.last  = (kk == kt - 1);
          exp_q.push_back(cur);
          exp_g.push_back(g);
        end
      end
    end
    n_fire = 0; n_last = 0; n_done = 0; first_fire = -1; last_fire = -1;
    last_ret = -1; done_cyc = -1; max_out = 0; busy_bad = 0; timed_out = 0;
    stalled = 0; got_done = 0; model_out = 0; held = '0;
    m_tiles_i = IDXW'(mt); n_tiles_i = IDXW'(nt); k_tiles_i = IDXW'(kt);
    start_i = 1'b1; cmd_ready_i = 1'b0; rsp_fire_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while (!got_done && !timed_out) begin
      if (cyc >= 4000) begin
        timed_out = 1;
      end else begin
        cur.m = cmd_m_o; cur.n = cmd_n_o; cur.k = cmd_k_o;
        cur.first = cmd_first_o; cur.last = cmd_last_o;
        if (stalled) begin
          checks++;
          if (cmd_valid_o !== 1'b1 || cur !== held) begin
            errors++;
            $display("FAIL hold: valid=%b cmd=%h, required valid=1 cmd=%h", cmd_valid_o, cur, held);
          end
        end
        if (done_o === 1'b1) begin
          got_done = 1; done_cyc = cyc; n_done++;
        end else begin
          if (busy_o !== 1'b1) busy_bad++;
          cmd_ready_i = ($urandom_range(99) < ready_pct);
          rsp_fire_i  = (ret_q.size() > 0 && ret_q[0] == cyc);
          fire        = (cmd_valid_o === 1'b1) && cmd_ready_i;
          if (fire) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL extra_cmd: cmd=%h issued, required none", cur);
            end else begin
              if (cur !== exp_q[0]) begin
                errors++;
                $display("FAIL order: cmd=%h, required %h", cur, exp_q[0]);
              end
              checks++;
              if (model_out >= exp_g[0]) begin
                errors++;
                $display("FAIL outstanding: %0d in flight at issue, required < %0d", model_out, exp_g[0]);
              end
              void'(exp_q.pop_front());
              void'(exp_g.pop_front());
            end
            lat = $urandom_range(lat_max, lat_min);
            ret_q.push_back((cyc + lat > last_ret + 1) ? cyc + lat : last_ret + 1);
            last_ret = ret_q[$];
            n_fire++;
            if (cur.last) n_last++;
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
          end
          if (rsp_fire_i) begin
            void'(ret_q.pop_front());
            model_out--;
          end
          if (fire) model_out++;
          if (model_out > max_out) max_out = model_out;
          stalled = (cmd_valid_o === 1'b1) && !cmd_ready_i;
          held = cur;
          @(negedge clk);
          cyc++;
        end
      end
    end
    cmd_ready_i = 1'b0; rsp_fire_i = 1'b0;
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL timeout: no done_o within 4000 cycles for %0dx%0dx%0d", mt, nt, kt);
    end
    checks++;
    if (exp_q.size() != 0 || n_fire != tot * kt) begin
      errors++;
      $display("FAIL cmd_count: %0d issued, required %0d", n_fire, tot * kt);
    end
    // done_o rises on the edge after the final retire empties the pipeline.
    checks++;
    if (!timed_out && done_cyc != last_ret + 2) begin
      errors++;
      $display("FAIL done_latency: done seen at %0d, required %0d", done_cyc, last_ret + 2);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL busy: low for %0d cycles mid-job, required 0", busy_bad);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL after_done: done=%b busy=%b err=%b, required 0 0 0", done_o, busy_o, err_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; cmd_ready_i = 1'b0; rsp_fire_i = 1'b0;
    m_tiles_i = '0; n_tiles_i = '0; k_tiles_i = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_o, done_o, err_o, cmd_valid_o, cmd_m_o, cmd_n_o, cmd_k_o, cmd_first_o, cmd_last_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b valid=%b m=%0d n=%0d k=%0d first=%b last=%b, required all 0",
               busy_o, done_o, err_o, cmd_valid_o, cmd_m_o, cmd_n_o, cmd_k_o, cmd_first_o, cmd_last_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || cmd_valid_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b valid=%b done=%b, required 0 0 0", busy_o, cmd_valid_o, done_o);
    end
  endtask

  task automatic test_single();
    run_job(1, 1, 1, 100, 3, 3);
    // issue edge to done edge is 4 cycles; seen one negedge after that edge
    checks++;
    if (n_fire != 1 || done_cyc - last_fire != 5) begin
      errors++;
      $display("FAIL single: cmds=%0d done_delta=%0d, required 1 and 5", n_fire, done_cyc - last_fire);
    end
  endtask

  task automatic test_order();
    run_job(1, 2, 3, 100, 2, 2);
    checks++;
    if (n_last != 2 || max_out > 2) begin
      errors++;
      $display("FAIL order_1x2x3: last_cmds=%0d max_outstanding=%0d, required 2 and <=2", n_last, max_out);
    end
  endtask

  task automatic test_groups();
    run_job(2, 3, 2, 100, 3, 3);
    checks++;
    if (n_fire != 12 || n_last != 6 || n_done != 1) begin
      errors++;
      $display("FAIL groups_2x3x2: cmds=%0d last=%0d done=%0d, required 12 6 1", n_fire, n_last, n_done);
    end
  endtask

  task automatic test_back_to_back();
    run_job(2, 2, 3, 100, 3, 3);
    checks++;
    if (last_fire - first_fire != 11) begin
      errors++;
      $display("FAIL throughput: 12 cmds spanned %0d cycles, required 11", last_fire - first_fire);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      if (it < 4) run_job(2, 3, 2, 60, 1, 6);
      else run_job($urandom_range(4, 1), $urandom_range(4, 1), $urandom_range(3, 1), 70, 1, 7);
      checks++;
      if (max_out > ILV) begin
        errors++;
        $display("FAIL random_outstanding: max %0d, required <= %0d", max_out, ILV);
      end
    end
  endtask

  task automatic test_zero_count();
    m_tiles_i = 8'd2; n_tiles_i = 8'd2; k_tiles_i = 8'd0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (err_o !== 1'b1 || done_o !== 1'b1 || cmd_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_k: err=%b done=%b valid=%b busy=%b, required 1 1 0 0", err_o, done_o, cmd_valid_o, busy_o);
    end
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1 || done_o !== 1'b0 || cmd_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_k_after: err=%b done=%b valid=%b, required 1 0 0", err_o, done_o, cmd_valid_o);
    end
    run_job(1, 1, 2, 100, 1, 1);
  endtask

  task automatic test_reset_mid_issue();
    m_tiles_i = 8'd2; n_tiles_i = 8'd2; k_tiles_i = 8'd3;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; cmd_ready_i = 1'b1; rsp_fire_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue: valid=%b busy=%b with 3 outstanding, required 1 1", cmd_valid_o, busy_o);
    end
    rst_i = 1'b1; cmd_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, err_o, cmd_valid_o, cmd_m_o, cmd_n_o, cmd_k_o, cmd_first_o, cmd_last_o} !== '0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b err=%b valid=%b m=%0d n=%0d k=%0d, required all 0",
               busy_o, done_o, err_o, cmd_valid_o, cmd_m_o, cmd_n_o, cmd_k_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
    rsp_fire_i = 1'b1;
    @(negedge clk);
    rsp_fire_i = 1'b0;
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || cmd_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stray_rsp: err=%b busy=%b valid=%b, required 1 0 0", err_o, busy_o, cmd_valid_o);
    end
    run_job(1, 2, 1, 100, 2, 2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_groups();
    test_back_to_back();
    test_random();
    test_zero_count();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
